dds_phase_detector: RTL and testbench

- Inverse of the DDS sine/cosine generator: takes a packed {sin, cos} sample and returns its phase atan2(sin, cos).
- Phase uses the DDS phase-word scaling: full scale 2^PHASE_DW = 2π, unsigned.
- Uses an iterative CORDIC in vectoring mode, one micro-rotation per clock, with AXI-stream handshakes on both sides.
- Used for DDS loopback verification and as a phase demodulator front end.

---
 rtl/dds_phase_detector.sv | 246 ++++++++++++++++++++++++
 tb/tb_dds_phase_detector.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_detector.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : dds_phase_detector                                            |
// | Description : Converts a packed {sin, cos} sample into its phase            |
// |               atan2(sin, cos) in DDS phase-word scaling (2^PHASE_DW = 2*pi) |
// |               using an iterative vectoring-mode CORDIC, one micro-rotation  |
// |               per clock, with AXI-stream handshakes on input and output.    |
// |               Optional magnitude output enabled by macro PHASE_DET_MAG_EN.  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module dds_phase_detector #(
   parameter int IN_DW      = 16,
   parameter int PHASE_DW   = 16,
   parameter int ITERATIONS = 16,   // legal range 4..PHASE_DW
   parameter int GUARD_DW   = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [2*IN_DW-1:0]    s_axis_in_tdata,
   input  logic                  s_axis_in_tvalid,
   output logic                  s_axis_in_tready,
   output logic [PHASE_DW-1:0]   m_axis_phase_tdata,
   output logic                  m_axis_phase_tvalid,
   input  logic                  m_axis_phase_tready
`ifdef PHASE_DET_MAG_EN
   ,
   output logic [IN_DW:0]        m_axis_mag_tdata
`endif
);

   // Two extra bits on x/y: one for negating -2^(IN_DW-1), one for CORDIC gain.
   localparam int c_XW = IN_DW + 2;
   // Angle accumulator carries GUARD_DW fractional bits below the phase LSB.
   localparam int c_ZW = PHASE_DW + GUARD_DW;
   localparam int c_CW = $clog2(ITERATIONS);
   localparam real c_PI = 3.14159265358979323846;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(ITERATIONS - 1);
   // Pi expressed in accumulator units (half of full scale).
   localparam logic [c_ZW-1:0] c_Z_PI = {1'b1, {(c_ZW-1){1'b0}}};
   // Half of one output LSB in accumulator units, for round-half-up.
   localparam logic [c_ZW-1:0] c_Z_HALF = (GUARD_DW > 0) ? c_ZW'(1 << (GUARD_DW - 1)) : '0;

   // atan(2^-idx) scaled so that 2*pi maps to 2^c_ZW, rounded to nearest.
   function automatic logic [c_ZW-1:0] f_atan_entry(input int idx);
      real ang;
      ang = $atan(1.0 / (2.0 ** idx)) / (2.0 * c_PI) * (2.0 ** c_ZW);
      return c_ZW'($rtoi(ang + 0.5));
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ROTATE = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic                    r_rdy_en;
   logic                    w_in_ready;
   logic                    w_in_xfer;
   logic                    w_out_xfer;
   logic                    w_last;

   logic signed [IN_DW-1:0] w_sin;
   logic signed [IN_DW-1:0] w_cos;
   logic signed [c_XW-1:0]  w_sin_ext;
   logic signed [c_XW-1:0]  w_cos_ext;
   logic signed [c_XW-1:0]  w_x0;
   logic signed [c_XW-1:0]  w_y0;
   logic [c_ZW-1:0]         w_z0;

   logic signed [c_XW-1:0]  r_x;
   logic signed [c_XW-1:0]  r_y;
   logic signed [c_XW-1:0]  w_x_sh;
   logic signed [c_XW-1:0]  w_y_sh;
   logic signed [c_XW-1:0]  w_x_next;
   logic signed [c_XW-1:0]  w_y_next;
   logic [c_ZW-1:0]         r_z;
   logic [c_ZW-1:0]         w_z_next;
   logic [c_ZW-1:0]         w_atan;
   logic [c_ZW-1:0]         w_atan_tbl [ITERATIONS];
   logic [c_CW-1:0]         r_iter;
   logic                    r_zero;
   logic [PHASE_DW-1:0]     r_phase;
   logic [PHASE_DW-1:0]     w_phase_rnd;

   // Arctangent table, one constant per micro-rotation, built at elaboration.
   generate
      for (genvar g = 0; g < ITERATIONS; g++) begin : g_atan
         localparam logic [c_ZW-1:0] c_VAL = f_atan_entry(g);
         assign w_atan_tbl[g] = c_VAL;
      end
   endgenerate

   assign w_sin     = s_axis_in_tdata[2*IN_DW-1:IN_DW];
   assign w_cos     = s_axis_in_tdata[IN_DW-1:0];
   assign w_sin_ext = {{2{w_sin[IN_DW-1]}}, w_sin};
   assign w_cos_ext = {{2{w_cos[IN_DW-1]}}, w_cos};

   // Fold the left half-plane onto the right by a pi rotation so the CORDIC
   // only has to cover +/- pi/2.
   assign w_x0 = w_cos[IN_DW-1] ? -w_cos_ext : w_cos_ext;
   assign w_y0 = w_cos[IN_DW-1] ? -w_sin_ext : w_sin_ext;
   assign w_z0 = w_cos[IN_DW-1] ? c_Z_PI : '0;

   assign w_in_xfer  = s_axis_in_tvalid & w_in_ready;
   assign w_out_xfer = m_axis_phase_tready & (r_state == ST_DONE);
   assign w_last     = (r_state == ST_ROTATE) && (r_iter == c_LAST);

   assign w_x_sh = r_x >>> r_iter;
   assign w_y_sh = r_y >>> r_iter;
   assign w_atan = w_atan_tbl[r_iter];

   // Round half-up to the phase width; the wrap at 2*pi is plain modulo.
   assign w_phase_rnd = PHASE_DW'((w_z_next + c_Z_HALF) >> GUARD_DW);

   // Input ready only after the first edge out of reset; passes through
   // the output ready while a result is waiting.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
      end
   end

   // Input-side ready decoded from the current state.
   always_comb begin
      w_in_ready = 1'b0;
      case (r_state)
         ST_IDLE:   w_in_ready = r_rdy_en;
         ST_ROTATE: w_in_ready = 1'b0;
         ST_DONE:   w_in_ready = m_axis_phase_tready;
         default:   w_in_ready = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: accept, rotate ITERATIONS cycles, hold until consumed.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_in_xfer) begin
               w_state_next = ST_ROTATE;
            end
         end
         ST_ROTATE: begin
            if (w_last) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (w_out_xfer) begin
               w_state_next = w_in_xfer ? ST_ROTATE : ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // One vectoring micro-rotation: drive y toward zero, accumulate angle.
   always_comb begin
      w_x_next = r_x;
      w_y_next = r_y;
      w_z_next = r_z;
      if (!r_y[c_XW-1]) begin
         w_x_next = r_x + w_y_sh;
         w_y_next = r_y - w_x_sh;
         w_z_next = r_z + w_atan;
      end else begin
         w_x_next = r_x - w_y_sh;
         w_y_next = r_y + w_x_sh;
         w_z_next = r_z - w_atan;
      end
   end

   // CORDIC datapath: load pre-rotated sample on accept, iterate, and
   // capture the rounded phase on the final iteration.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_iter  <= '0;
         r_zero  <= 1'b0;
         r_phase <= '0;
      end else if (w_in_xfer) begin
         r_x     <= w_x0;
         r_y     <= w_y0;
         r_z     <= w_z0;
         r_iter  <= '0;
         r_zero  <= (s_axis_in_tdata == '0);
      end else if (r_state == ST_ROTATE) begin
         r_x     <= w_x_next;
         r_y     <= w_y_next;
         r_z     <= w_z_next;
         r_iter  <= w_last ? '0 : r_iter + c_CW'(1);
         if (w_last) begin
            // The all-zero vector has no defined angle; report zero.
            r_phase <= r_zero ? '0 : w_phase_rnd;
         end
      end
   end

   assign s_axis_in_tready    = w_in_ready;
   assign m_axis_phase_tvalid = (r_state == ST_DONE);
   assign m_axis_phase_tdata  = r_phase;

`ifdef PHASE_DET_MAG_EN
   localparam int c_PW = c_XW + 17;
   // CORDIC gain compensation, round(0.607253 * 2^16).
   localparam logic [16:0] c_K = 17'd39797;

   logic [c_PW-1:0]  w_prod;
   logic [c_XW:0]    w_mag_q;
   logic [IN_DW:0]   w_mag_sat;
   logic [IN_DW:0]   r_mag;

   // x is non-negative after the half-plane fold, so an unsigned multiply suffices.
   assign w_prod    = {17'd0, w_x_next} * {{c_XW{1'b0}}, c_K};
   assign w_mag_q   = (c_XW + 1)'((w_prod + c_PW'(32768)) >> 16);
   assign w_mag_sat = (|w_mag_q[c_XW:IN_DW+1]) ? '1 : w_mag_q[IN_DW:0];

   // Magnitude captured alongside the phase, sharing its handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mag <= '0;
      end else if (w_last) begin
         r_mag <= r_zero ? '0 : w_mag_sat;
      end
   end

   assign m_axis_mag_tdata = r_mag;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dds_phase_detector.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_dds_phase_detector                                         |
// | Description : Directed self-checking bench for dds_phase_detector: axes,    |
// |               diagonals, wrap-around, zero input, latency, backpressure and |
// |               reset during rotation and while holding a result.            |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_dds_phase_detector;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] s_axis_in_tdata;
   logic        s_axis_in_tvalid;
   logic        s_axis_in_tready;
   logic [15:0] m_axis_phase_tdata;
   logic        m_axis_phase_tvalid;
   logic        m_axis_phase_tready;
`ifdef PHASE_DET_MAG_EN
   logic [16:0] m_axis_mag_tdata;
`endif

   always #5 clk = ~clk;

   dds_phase_detector #(
      .IN_DW      (16),
      .PHASE_DW   (16),
      .ITERATIONS (16),
      .GUARD_DW   (2)
   ) u_dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .s_axis_in_tdata     (s_axis_in_tdata),
      .s_axis_in_tvalid    (s_axis_in_tvalid),
      .s_axis_in_tready    (s_axis_in_tready),
      .m_axis_phase_tdata  (m_axis_phase_tdata),
      .m_axis_phase_tvalid (m_axis_phase_tvalid),
      .m_axis_phase_tready (m_axis_phase_tready)
`ifdef PHASE_DET_MAG_EN
      ,
      .m_axis_mag_tdata    (m_axis_mag_tdata)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Returns exp when act is within tol of exp modulo 2^16, else act itself.
   function automatic longint snap_phase(input longint act, input longint exp, input int tol);
      int d;
      d = int'((act - exp) & 64'hFFFF);
      if (d > 32767) d -= 65536;
      if (d >= -tol && d <= tol) return exp;
      return act;
   endfunction

   function automatic longint snap_lin(input longint act, input longint exp, input int tol);
      if (act >= exp - tol && act <= exp + tol) return exp;
      return act;
   endfunction

   task automatic wait_in_ready();
      int w;
      w = 0;
      while (s_axis_in_tready !== 1'b1 && w < 50) begin
         @(posedge clk); #1;
         w++;
      end
      check("in_ready_wait", longint'(s_axis_in_tready), 1);
   endtask

   // Present one sample and hold it for exactly the accepting edge.
   task automatic accept(input int s, input int c);
      wait_in_ready();
      s_axis_in_tdata  = {16'(s), 16'(c)};
      s_axis_in_tvalid = 1'b1;
      @(posedge clk); #1;
      s_axis_in_tvalid = 1'b0;
   endtask

   // Edges counted from the accept edge until the result is valid (bounded).
   task automatic wait_valid(output int lat);
      lat = 0;
      while (m_axis_phase_tvalid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   int v_sin[12] = '{0, 32767, 0, -32767, 23170, 23170, -23170, -23170, -32768, -1, 1, 0};
   int v_cos[12] = '{32767, 0, -32768, 0, 23170, -23170, -23170, 23170, -32768, 32767, -32767, 0};
   int v_ph [12] = '{'h0000, 'h4000, 'h8000, 'hC000, 'h2000, 'h6000, 'hA000, 'hE000,
                     'hA000, 'h0000, 'h8000, 'h0000};
   int v_tol[12] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 1, 2, 0};
   int v_mag[12] = '{32767, 32767, 32768, 32767, 32767, 32767, 32767, 32767,
                     46341, 32767, 32767, 0};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int cnt;
      int bad_data;
      int bad_rdy;
      int bad_vld;
      logic [15:0] held;

      reset_n             = 1'b0;
      s_axis_in_tdata     = '0;
      s_axis_in_tvalid    = 1'b0;
      m_axis_phase_tready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      check("reset_tvalid", longint'(m_axis_phase_tvalid), 0);
      check("reset_tdata", longint'(m_axis_phase_tdata), 0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("release_in_ready", longint'(s_axis_in_tready), 1);

      // Directed vectors with immediate drain.
      for (int i = 0; i < 12; i++) begin
         accept(v_sin[i], v_cos[i]);
         wait_valid(lat);
         check($sformatf("lat_%0d", i), lat, 16);
         check($sformatf("phase_%0d", i),
               snap_phase(longint'(m_axis_phase_tdata), v_ph[i], v_tol[i]), v_ph[i]);
`ifdef PHASE_DET_MAG_EN
         check($sformatf("mag_%0d", i),
               snap_lin(longint'(m_axis_mag_tdata), v_mag[i], (v_tol[i] == 0) ? 0 : 4), v_mag[i]);
`endif
         @(posedge clk); #1;
         check($sformatf("drain_%0d", i), longint'(m_axis_phase_tvalid), 0);
      end

      // Backpressure with a pending upstream sample.
      m_axis_phase_tready = 1'b0;
      accept(0, 32767);
      wait_valid(lat);
      check("bp_lat", lat, 16);
      held = m_axis_phase_tdata;
      check("bp_phase", snap_phase(longint'(held), 0, 2), 0);
      s_axis_in_tdata  = {16'(32767), 16'(0)};
      s_axis_in_tvalid = 1'b1;
      bad_data = 0;
      bad_rdy  = 0;
      bad_vld  = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (m_axis_phase_tdata !== held) bad_data++;
         if (s_axis_in_tready !== 1'b0) bad_rdy++;
         if (m_axis_phase_tvalid !== 1'b1) bad_vld++;
      end
      check("bp_data_stable", bad_data, 0);
      check("bp_in_ready_low", bad_rdy, 0);
      check("bp_valid_held", bad_vld, 0);
      m_axis_phase_tready = 1'b1;
      #1;
      check("bp_in_ready_follow", longint'(s_axis_in_tready), 1);
      @(posedge clk); #1;
      s_axis_in_tvalid = 1'b0;
      check("bp_valid_drop", longint'(m_axis_phase_tvalid), 0);
      wait_valid(lat);
      check("bp_next_lat", lat, 16);
      check("bp_next_phase", snap_phase(longint'(m_axis_phase_tdata), 'h4000, 2), 'h4000);
      @(posedge clk); #1;

      // Reset at rotation iteration 5.
      accept(0, -32768);
      repeat (5) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      check("rst_rot_valid", longint'(m_axis_phase_tvalid), 0);
      check("rst_rot_data", longint'(m_axis_phase_tdata), 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("rst_rot_ready", longint'(s_axis_in_tready), 1);
      cnt = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (m_axis_phase_tvalid === 1'b1) cnt++;
      end
      check("rst_rot_no_out", cnt, 0);

      // Reset while a result is held.
      m_axis_phase_tready = 1'b0;
      accept(23170, 23170);
      wait_valid(lat);
      check("rst_done_lat", lat, 16);
      check("rst_done_phase", snap_phase(longint'(m_axis_phase_tdata), 'h2000, 2), 'h2000);
      reset_n = 1'b0;
      #1;
      check("rst_done_valid", longint'(m_axis_phase_tvalid), 0);
      check("rst_done_data", longint'(m_axis_phase_tdata), 0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      m_axis_phase_tready = 1'b1;
      cnt = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (m_axis_phase_tvalid === 1'b1) cnt++;
      end
      check("rst_done_no_out", cnt, 0);

      // Recovery after reset.
      accept(-32767, 0);
      wait_valid(lat);
      check("recover_lat", lat, 16);
      check("recover_phase", snap_phase(longint'(m_axis_phase_tdata), 'hC000, 2), 'hC000);
      @(posedge clk); #1;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
